// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions.
// Widths, memory size and the fetch-buffer entry type.
package Def;

    localparam int ADDR_SIZE  = 5;
    localparam int DATA_SIZE  = 32;
    localparam int MEM_LEN    = 32;
    localparam int FBUF_DEPTH = 4;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] pc;
        logic [DATA_SIZE-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Fetch buffer: synchronous FIFO with clear and full-with-pop bypass.
// Occupancy counter separates full from empty.
module fetch_fifo
    import Def::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = FBUF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   can_push
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    T               mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           wr;
    logic           rd;

    assign can_push = (count != FULL) || pop;
    assign wr       = push && can_push;
    assign rd       = pop && (count != '0);
    assign head     = mem[rd_ptr];

    // Entry storage; pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy update; clear drops everything.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{PW{1'b0}}, wr} - {{PW{1'b0}}, rd};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Front end: PC, redirect target, fetch buffer arbitration,
// flush pulse and program-done flag.
module fetch_unit #(
    parameter int ADDR_W     = Def::ADDR_SIZE,
    parameter int MEM_LEN    = Def::MEM_LEN,
    parameter int DATA_W     = Def::DATA_SIZE,
    parameter int FBUF_DEPTH = Def::FBUF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [DATA_W-1:0]           imem_rdata,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_base,
    input  logic [ADDR_W-1:0]           redirect_offset,
    input  logic                        redirect_dir,
    input  logic                        stall,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_inst,
    output logic [ADDR_W-1:0]           out_pc,
    output logic                        flush,
    output logic                        done,
    output logic [$clog2(FBUF_DEPTH):0] buf_count
);

    localparam logic [ADDR_W:0] LEN = (ADDR_W+1)'(MEM_LEN);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    logic [ADDR_W:0] pc;
    logic [ADDR_W:0] target;
    logic            in_range;
    logic            push_req;
    logic            pop;
    logic            can_push;
    entry_t          din;
    entry_t          head;

    assign in_range  = pc < LEN;
    assign push_req  = in_range && !redirect_valid;
    assign pop       = out_valid && !stall && !redirect_valid;
    assign imem_addr = pc[ADDR_W-1:0];
    assign din       = '{pc: pc[ADDR_W-1:0], inst: imem_rdata};

    // Underflow wraps in ADDR_W+1 bits and lands beyond memory.
    assign target = redirect_dir
        ? {1'b0, redirect_base} - {1'b0, redirect_offset}
        : {1'b0, redirect_base} + {1'b0, redirect_offset};

    fetch_fifo #(
        .T     (entry_t),
        .DEPTH (FBUF_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (redirect_valid),
        .push     (push_req),
        .pop      (pop),
        .din      (din),
        .head     (head),
        .count    (buf_count),
        .can_push (can_push)
    );

    assign out_valid = buf_count != '0;
    assign out_inst  = out_valid ? head.inst : '0;
    assign out_pc    = out_valid ? head.pc : '0;

    // PC: redirect wins, otherwise advance on every accepted push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (redirect_valid) begin
            pc <= target;
        end else if (push_req && can_push) begin
            pc <= pc + 1'b1;
        end
    end

    // Flush follows each accepted redirect by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush <= 1'b0;
        end else begin
            flush <= redirect_valid;
        end
    end

    // Done sets once fetch ran off and the buffer drained; sticky
    // unless a redirect brings the PC back into memory.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else if (redirect_valid) begin
            done <= done && (target >= LEN);
        end else begin
            done <= done || (!in_range && buf_count == '0);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed table, straight-line run,
// randomized traffic against a queue-based reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [4:0]  redirect_base;
    logic [4:0]  redirect_offset;
    logic        redirect_dir;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [4:0]  out_pc;
    logic        flush;
    logic        done;
    logic [2:0]  buf_count;

    logic [31:0] mem [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_base   (redirect_base),
        .redirect_offset (redirect_offset),
        .redirect_dir    (redirect_dir),
        .stall           (stall),
        .out_valid       (out_valid),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .flush           (flush),
        .done            (done),
        .buf_count       (buf_count)
    );

    typedef struct {
        int          pc;
        logic [31:0] inst;
    } ent_t;

    ent_t q[$];
    int   mpc;
    bit   mflush;
    bit   mdone;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  t;
        bit  drained;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            mpc = 0;
            mflush = 0;
            mdone = 0;
        end else if (redirect_valid) begin
            if (redirect_dir) t = int'(redirect_base) - int'(redirect_offset);
            else t = int'(redirect_base) + int'(redirect_offset);
            t = t & 63;
            mdone = mdone && (t >= 32);
            q.delete();
            mpc = t;
            mflush = 1;
        end else begin
            drained = (mpc >= 32) && (q.size() == 0);
            if (q.size() > 0 && !stall) void'(q.pop_front());
            if (mpc < 32 && q.size() < 4) begin
                e.pc = mpc;
                e.inst = mem[mpc];
                q.push_back(e);
                mpc++;
            end
            mdone = mdone || drained;
            mflush = 0;
        end
    endtask

    task automatic model_check();
        bit v;
        v = q.size() > 0;
        chk("m_valid", out_valid, v);
        chk("m_pc", out_pc, v ? q[0].pc : 0);
        chk("m_inst", out_inst, v ? q[0].inst : 0);
        chk("m_count", buf_count, q.size());
        chk("m_addr", imem_addr, mpc & 31);
        chk("m_flush", flush, mflush);
        chk("m_done", done, mdone);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    typedef struct {
        bit rst_n, stall, rv, dir;
        int base, off;
        bit ev;
        int epc, ecnt, eaddr;
        bit efl, edn;
    } vec_t;

    function automatic vec_t mk(bit r, bit s, bit rv, int b, int o, bit d,
                                bit ev, int epc, int ecnt, int ea,
                                bit efl, bit edn);
        vec_t v;
        v.rst_n = r; v.stall = s; v.rv = rv; v.base = b; v.off = o;
        v.dir = d; v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.eaddr = ea;
        v.efl = efl; v.edn = edn;
        return v;
    endfunction

    vec_t tv [19];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        rst_n = 0; stall = 0; redirect_valid = 0;
        redirect_base = 0; redirect_offset = 0; redirect_dir = 0;

        //        rst s rv bs of d  v pc cnt ad fl dn
        tv[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        tv[2]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 1, 2, 0, 0);
        tv[3]  = mk(1, 1, 0, 0, 0, 0, 1, 1, 2, 3, 0, 0);
        tv[4]  = mk(1, 1, 0, 0, 0, 0, 1, 1, 3, 4, 0, 0);
        tv[5]  = mk(1, 1, 0, 0, 0, 0, 1, 1, 4, 5, 0, 0);
        tv[6]  = mk(1, 1, 0, 0, 0, 0, 1, 1, 4, 5, 0, 0);
        tv[7]  = mk(1, 1, 0, 0, 0, 0, 1, 1, 4, 5, 0, 0);
        tv[8]  = mk(1, 0, 0, 0, 0, 0, 1, 2, 4, 6, 0, 0);
        tv[9]  = mk(1, 0, 0, 0, 0, 0, 1, 3, 4, 7, 0, 0);
        tv[10] = mk(1, 1, 1, 6, 4, 0, 0, 0, 0, 10, 1, 0);
        tv[11] = mk(1, 0, 0, 0, 0, 0, 1, 10, 1, 11, 0, 0);
        tv[12] = mk(1, 0, 0, 0, 0, 0, 1, 11, 1, 12, 0, 0);
        tv[13] = mk(1, 0, 1, 2, 5, 1, 0, 0, 0, 29, 1, 0);
        tv[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 29, 0, 1);
        tv[15] = mk(1, 0, 1, 3, 0, 0, 0, 0, 0, 3, 1, 0);
        tv[16] = mk(1, 0, 1, 20, 10, 0, 0, 0, 0, 30, 1, 0);
        tv[17] = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tv[18] = mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);

        for (int i = 0; i < 19; i++) begin
            rst_n = tv[i].rst_n;
            stall = tv[i].stall;
            redirect_valid = tv[i].rv;
            redirect_base = 5'(tv[i].base);
            redirect_offset = 5'(tv[i].off);
            redirect_dir = tv[i].dir;
            tick();
            chk($sformatf("tv%0d_valid", i), out_valid, tv[i].ev);
            chk($sformatf("tv%0d_pc", i), out_pc, tv[i].epc);
            chk($sformatf("tv%0d_inst", i), out_inst,
                tv[i].ev ? mem[tv[i].epc] : 0);
            chk($sformatf("tv%0d_count", i), buf_count, tv[i].ecnt);
            chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].eaddr);
            chk($sformatf("tv%0d_flush", i), flush, tv[i].efl);
            chk($sformatf("tv%0d_done", i), done, tv[i].edn);
        end

        // straight line: 0..31 back to back, done two cycles after 31
        rst_n = 0; stall = 0; redirect_valid = 0;
        tick();
        rst_n = 1;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("sl_valid", out_valid, 1);
            chk("sl_pc", out_pc, i);
        end
        tick();
        chk("sl_done_early", done, 0);
        chk("sl_empty", buf_count, 0);
        tick();
        chk("sl_done", done, 1);
        tick();
        chk("sl_done_hold", done, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = $urandom_range(0, 199) != 0;
            stall = $urandom_range(0, 3) == 0;
            redirect_valid = $urandom_range(0, 11) == 0;
            redirect_base = 5'($urandom_range(0, 31));
            redirect_offset = 5'($urandom_range(0, 31));
            redirect_dir = 1'($urandom_range(0, 1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
